// File: rtl/wb_user_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the user project slave port.
// Round-robin or fixed-priority grant per bus cycle, plus a stall watchdog that aborts hung transfers with err.
module wb_user_arbiter #(
  parameter int          PRIORITY_MODE  = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // A disabled watchdog still keeps a 1-bit counter so the declarations stay legal.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, ABORT, RELEASE} state_t;

  state_t        state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] stall_cnt;

  logic req0, req1, own_cyc, granted, stall, limit_hit;

  assign req0      = m0_cyc_i & m0_stb_i;
  assign req1      = m1_cyc_i & m1_stb_i;
  assign own_cyc   = owner ? m1_cyc_i : m0_cyc_i;
  assign granted   = (state == GRANT0) || (state == GRANT1);
  assign stall     = granted && s_stb_o && !s_ack_i;
  assign limit_hit = (TIMEOUT_CYCLES > 0) && stall && (stall_cnt == LIMIT);

  assign grant_o   = {state == GRANT1, state == GRANT0};
  assign timeout_o = (state == ABORT);

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GRANT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
      GRANT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end
      ABORT: begin
        if (owner) begin
          m1_err_o = 1'b1;
          m1_dat_o = ERR_DATA;
        end else begin
          m0_err_o = 1'b1;
          m0_dat_o = ERR_DATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      stall_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          // last_grant == 1 means master 0 wins a round-robin tie.
          if (req0 && (!req1 || PRIORITY_MODE == 1 || last_grant)) begin
            state <= GRANT0;
            owner <= 1'b0;
          end else if (req1) begin
            state <= GRANT1;
            owner <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (!own_cyc) begin
            state      <= IDLE;
            last_grant <= owner;
            stall_cnt  <= '0;
          end else if (limit_hit) begin
            state      <= ABORT;
            last_grant <= owner;
            stall_cnt  <= '0;
          end else if (stall) begin
            if (TIMEOUT_CYCLES > 0) stall_cnt <= stall_cnt + CW'(1);
          end else begin
            stall_cnt <= '0;
          end
        end
        ABORT: state <= RELEASE;
        RELEASE: begin
          if (!own_cyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_user_arbiter.sv
// Directed bench for wb_user_arbiter: one round-robin/T=4 instance and one fixed-priority/watchdog-off instance share stimulus.
module tb_wb_user_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;

  logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat, b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we, a_timeout;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we, b_timeout;
  logic [3:0]  a_s_sel, b_s_sel;
  logic [1:0]  a_grant, b_grant;

  int n_checks = 0;
  int n_fail   = 0;
  int bad      = 0;

  always #5 clk = ~clk;

  wb_user_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) dut_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_sel_o(a_s_sel),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant_o(a_grant), .timeout_o(a_timeout)
  );

  wb_user_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)) dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant_o(b_grant), .timeout_o(b_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_adr = '0; m0_dat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_adr = '0; m1_dat = '0;
    s_ack = 0; s_dat = 32'hCAFE_0001;
  endtask

  // Leaves time 1 ns after a rising edge with both instances idle.
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    #3;
    chk("reset_s_cyc", a_s_cyc, 0);
    chk("reset_s_stb", a_s_stb, 0);
    chk("reset_grant", a_grant, 0);
    chk("reset_m0_ack", a_m0_ack, 0);
    chk("reset_timeout", a_timeout, 0);
    chk("reset_b_grant", b_grant, 0);
    $display("reset: outputs idle under reset");

    // m0 single write, ack on the second strobe cycle
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h3000_0000; m0_dat = 32'h1234_5678;
    @(negedge clk);
    chk("wr_idle_grant", a_grant, 2'b00);
    chk("wr_idle_stb", a_s_stb, 0);
    step();
    @(negedge clk);
    chk("wr_grant", a_grant, 2'b01);
    chk("wr_s_adr", a_s_adr, 32'h3000_0000);
    chk("wr_s_dat", a_s_dat, 32'h1234_5678);
    chk("wr_s_we", a_s_we, 1);
    chk("wr_s_sel", a_s_sel, 4'hF);
    chk("wr_ack_early", a_m0_ack, 0);
    step();
    s_ack = 1;
    @(negedge clk);
    chk("wr_ack", a_m0_ack, 1);
    chk("wr_m1_ack", a_m1_ack, 0);
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    @(negedge clk);
    chk("wr_ack_once", a_m0_ack, 0);
    step();
    @(negedge clk);
    chk("wr_grant_end", a_grant, 2'b00);
    $display("write: m0 adr 30000000 dat 12345678 acked");

    // Round-robin with both masters requesting
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("rr_idle", a_grant, 2'b00);
      step();
      @(negedge clk);
      chk("rr_grant", a_grant, (r % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_ack_owner", (r % 2 == 0) ? a_m0_ack : a_m1_ack, 1);
      chk("rr_ack_other", (r % 2 == 0) ? a_m1_ack : a_m0_ack, 0);
      step();
      if (r % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end else begin m1_cyc = 0; m1_stb = 0; end
      s_ack = 0;
      step();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
      $display("rr: round %0d grant %b", r, (r % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Fixed priority: m0 keeps winning while it requests
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("pri_idle", b_grant, 2'b00);
      step();
      @(negedge clk);
      chk("pri_grant_m0", b_grant, 2'b01);
      chk("pri_m1_ack", b_m1_ack, 0);
      step();
      m0_cyc = 0; m0_stb = 0; s_ack = 0;
      step();
      s_ack = 1;
      if (r < 2) begin m0_cyc = 1; m0_stb = 1; end
      $display("pri: round %0d m0 granted", r);
    end
    @(negedge clk);
    chk("pri_idle_last", b_grant, 2'b00);
    step();
    @(negedge clk);
    chk("pri_grant_m1", b_grant, 2'b10);
    $display("pri: m1 granted after m0 idles");

    // Watchdog abort on m1 read with TIMEOUT_CYCLES=4
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000_0040; s_dat = 32'h0BAD_F00D;
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_stall_grant", a_grant, 2'b10);
      chk("to_stall_timeout", a_timeout, 0);
      chk("to_stall_err", a_m1_err, 0);
      if (i == 0) chk("to_rd_route", a_m1_dat, 32'h0BAD_F00D);
      step();
    end
    @(negedge clk);
    chk("to_abort_err", a_m1_err, 1);
    chk("to_abort_dat", a_m1_dat, 32'hDEAD_BEEF);
    chk("to_abort_ack", a_m1_ack, 0);
    chk("to_abort_pulse", a_timeout, 1);
    chk("to_abort_s_cyc", a_s_cyc, 0);
    chk("to_abort_grant", a_grant, 2'b00);
    step();
    s_ack = 1; m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    chk("to_late_ack", a_m1_ack, 0);
    chk("to_rel_err", a_m1_err, 0);
    chk("to_pulse_end", a_timeout, 0);
    chk("to_rel_s_cyc", a_s_cyc, 0);
    step();
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk);
    chk("to_rel_grant", a_grant, 2'b00);
    step();
    @(negedge clk);
    chk("to_idle_grant", a_grant, 2'b00);
    step();
    @(negedge clk);
    chk("to_m0_after", a_grant, 2'b01);
    $display("timeout: m1 aborted with err, m0 granted afterwards");

    // Ack on the limit cycle wins over the watchdog
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lim_stall_ack", a_m0_ack, 0);
      step();
    end
    s_ack = 1;
    @(negedge clk);
    chk("lim_ack", a_m0_ack, 1);
    chk("lim_err", a_m0_err, 0);
    chk("lim_timeout", a_timeout, 0);
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    @(negedge clk);
    chk("lim_grant_hold", a_grant, 2'b01);
    chk("lim_timeout2", a_timeout, 0);
    chk("lim_err2", a_m0_err, 0);
    step();
    @(negedge clk);
    chk("lim_idle", a_grant, 2'b00);
    chk("lim_timeout3", a_timeout, 0);
    $display("limit: ack on 4th strobe cycle, no abort");

    // Watchdog disabled: 1000 stalled cycles never abort
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    step();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (b_timeout !== 1'b0 || b_grant !== 2'b01 || b_m0_err !== 1'b0) bad++;
      step();
    end
    chk("nowd_bad_cycles", bad, 0);
    chk("nowd_grant", b_grant, 2'b01);
    $display("nowd: 1000 stalled cycles without abort");

    // Async reset in the middle of a GRANT1 cycle
    do_reset();
    m1_cyc = 1; m1_stb = 1; s_ack = 1;
    step();
    @(negedge clk);
    chk("ar_pre_cyc", a_s_cyc, 1);
    chk("ar_pre_grant", a_grant, 2'b10);
    chk("ar_pre_ack", a_m1_ack, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_s_cyc", a_s_cyc, 0);
    chk("ar_grant", a_grant, 2'b00);
    chk("ar_m1_ack", a_m1_ack, 0);
    m0_cyc = 1; m0_stb = 1;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    chk("ar_first_m0", a_grant, 2'b01);
    $display("async reset: outputs cleared, m0 wins first tie");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_user_arbiter.md
Name: wb_user_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter placed in front of the user project's single Wishbone slave port.
- Master 0 is the management SoC Wishbone. Master 1 is a logic-analyzer-driven bus bridge.
- Grants the slave to one master per bus cycle (held while that master's cyc is high).
- A stall watchdog terminates a hung transfer with err and reports it.

Parameters:
- PRIORITY_MODE, 0: 0 = round-robin; 1 = fixed priority, m0 wins.
- TIMEOUT_CYCLES, 255: consecutive stalled strobe cycles before abort; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF: value driven on the aborted master's dat_o during its err cycle.

Ports:
- wb_clk_i  in  1  clock; all state changes on its rising edge
- wb_rst_ni  in  1  asynchronous active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe, write enable
- m0_sel_i  in  4  master 0 byte selects
- m0_adr_i, m0_dat_i  in  32 each  master 0 address, write data
- m0_dat_o  out  32  master 0 read data
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge, error
- m1_*  same set and widths as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable
- s_sel_o  out  4  slave byte selects
- s_adr_o, s_dat_o  out  32 each  slave address, write data
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave acknowledge
- grant_o  out  2  one-hot current owner; 00 = none
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, wb_rst_ni low):
  - state = IDLE; last_grant = 1, so m0 wins the first round-robin tie; stall counter = 0.
  - All outputs 0 immediately, including s_cyc_o and s_stb_o, with no clock required.
- Request: req_k = mk_cyc_i & mk_stb_i.
- States: IDLE, GRANT0, GRANT1, ABORT, RELEASE.
- IDLE:
  - s_* outputs 0; all master ack/err/dat_o outputs 0.
  - No request: stay in IDLE.
  - Single request: go to GRANTk.
  - Both requesting: PRIORITY_MODE=1 → GRANT0; PRIORITY_MODE=0 → the master not equal to last_grant.
  - Arbitration latency is 1 cycle: slave strobe first appears the cycle after the request.
- GRANTk, combinational routing:
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o = mk inputs.
  - mk_ack_o = s_ack_i; mk_dat_o = s_dat_i.
  - The other master's ack/err/dat_o = 0.
- GRANTk, hold and exit:
  - Grant persists across multiple strobes while mk_cyc_i = 1; the other master's requests wait.
  - mk_cyc_i = 0 → IDLE next cycle and last_grant = k.
  - A minimum of one IDLE cycle always separates grants.
- Watchdog (GRANTk only):
  - Counter increments each cycle with s_stb_o = 1 and s_ack_i = 0.
  - Counter clears on s_ack_i = 1, on s_stb_o = 0, and on leaving GRANTk.
  - Counter width = clog2(TIMEOUT_CYCLES+1); it never wraps.
  - When the counter equals TIMEOUT_CYCLES-1 and s_ack_i = 0 → ABORT next cycle. This is TIMEOUT_CYCLES stalled cycles.
  - Ack on the same cycle as the limit: ack wins, no abort.
- ABORT, exactly 1 cycle:
  - s_cyc_o = s_stb_o = 0.
  - mk_err_o = 1, mk_ack_o = 0, mk_dat_o = ERR_DATA.
  - timeout_o = 1.
  - last_grant = k. Next state RELEASE.
- RELEASE:
  - s_* outputs 0; mk outputs 0.
  - Wait for mk_cyc_i = 0, then go to IDLE.
  - A late s_ack_i arriving in ABORT or RELEASE is ignored and never forwarded.
- grant_o: 01 in GRANT0, 10 in GRANT1; 00 in IDLE, ABORT and RELEASE.
- Protocol assumptions:
  - Masters keep cyc high until they receive ack/err.
  - Master stb dropping mid-cycle without ack is legal: the counter clears.
- Master cyc dropping during GRANTk while s_ack_i = 1: that ack is still forwarded that cycle, then go to IDLE.

Test Plan:
- Reset, then m0 single write: adr 0x3000_0000, dat 0x1234_5678, slave acks on the 2nd strobe cycle → s_adr_o/s_dat_o match; m0_ack_o high 1 cycle; grant_o 01 then 00.
- Round-robin, m0 and m1 request in the same cycle, repeated for 4 cycles, slave acks immediately → grants alternate m0, m1, m0, m1, each separated by 1 IDLE cycle.
- PRIORITY_MODE=1, both masters request continuously → m1 never granted while m0 keeps requesting; m1 granted once m0 idles.
- TIMEOUT_CYCLES=4, m1 read, slave never acks → ABORT entered after 4 stalled cycles; m1_err_o = 1 with m1_dat_o = 0xDEAD_BEEF; timeout_o single pulse. Slave ack injected in RELEASE is not seen at m1. After m1 drops cyc, m0 is granted.
- Boundary: TIMEOUT_CYCLES=4, ack on the 4th stalled cycle → normal ack, no err, timeout_o stays 0. TIMEOUT_CYCLES=0 with 1000 stall cycles → no abort.
- Async reset asserted mid-GRANT1 between clock edges → s_cyc_o, grant_o and m1_ack_o go 0 immediately. After release, a simultaneous request is granted to m0 first.
